// File: rtl/iobuf_bank.sv
// Bank of bidirectional IO channels driving external level-shift buffers and SB_IO tristates.
// Each channel sequences buffer direction and FPGA output enable with a dead time between them.
module iobuf_bank #(
  parameter int CHANNELS    = 5,
  parameter int TURN_CYCLES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   oe,
  input  logic [CHANNELS-1:0]   od,
  input  logic [CHANNELS-1:0]   dout,
  output logic [CHANNELS-1:0]   din,
  output logic [CHANNELS-1:0]   rise,
  output logic [CHANNELS-1:0]   fall,
  output logic [CHANNELS-1:0]   busy,
  output logic [CHANNELS-1:0]   bufdir,
  output logic [CHANNELS-1:0]   bufod,
  output logic [CHANNELS-1:0]   buftoe,
  output logic [CHANNELS-1:0]   buftdo,
  input  logic [CHANNELS-1:0]   buftdi,
  output logic [2*CHANNELS-1:0] chan_state
);

  localparam int CW = $clog2(TURN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IN       = 2'd0,
    ST_TURN_OUT = 2'd1,
    ST_OUT      = 2'd2,
    ST_TURN_IN  = 2'd3
  } chan_state_t;

  chan_state_t         state_q [CHANNELS];
  chan_state_t         state_d [CHANNELS];
  logic [CW-1:0]       cnt_q   [CHANNELS];
  logic [CW-1:0]       cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] od_l_q;
  logic [CHANNELS-1:0] od_l_d;
  logic [CHANNELS-1:0] bufod_d;
  logic [CHANNELS-1:0] bufdir_d;
  logic [CHANNELS-1:0] buftoe_d;
  logic [CHANNELS-1:0] busy_d;
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] din_prev;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    od_l_d   = od_l_q;
    bufod_d  = bufod;
    bufdir_d = '0;
    buftoe_d = '0;
    busy_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (state_q[i])
        ST_IN: begin
          if (oe[i]) begin
            od_l_d[i]  = od[i];
            bufod_d[i] = od[i];
            cnt_d[i]   = '0;
            state_d[i] = ST_TURN_OUT;
          end
        end
        ST_TURN_OUT: begin
          // Dropping oe here is safe: the FPGA has not driven the pin yet.
          if (!oe[i]) begin
            cnt_d[i]   = '0;
            bufod_d[i] = 1'b0;
            state_d[i] = ST_IN;
          end else if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]   = '0;
            state_d[i] = ST_OUT;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        ST_OUT: begin
          if (!oe[i] || (od[i] != od_l_q[i])) begin
            cnt_d[i]   = '0;
            state_d[i] = ST_TURN_IN;
          end
        end
        ST_TURN_IN: begin
          if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]   = '0;
            bufod_d[i] = 1'b0;
            state_d[i] = ST_IN;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          cnt_d[i]   = '0;
          bufod_d[i] = 1'b0;
          state_d[i] = ST_IN;
        end
      endcase
      // Outputs are registered from the next state so they line up with the state register.
      bufdir_d[i] = (state_d[i] != ST_IN);
      buftoe_d[i] = (state_d[i] == ST_OUT);
      busy_d[i]   = (state_d[i] == ST_TURN_OUT) || (state_d[i] == ST_TURN_IN);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_IN;
        cnt_q[i]   <= '0;
      end
      od_l_q <= '0;
      bufod  <= '0;
      bufdir <= '0;
      buftoe <= '0;
      busy   <= '0;
      buftdo <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      od_l_q <= od_l_d;
      bufod  <= bufod_d;
      bufdir <= bufdir_d;
      buftoe <= buftoe_d;
      busy   <= busy_d;
      buftdo <= dout;
    end
  end

  // Input path runs in every state, so a driven pin reads back through the same chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      din_prev <= '0;
      rise     <= '0;
      fall     <= '0;
    end else begin
      sync_q[0] <= buftdi;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      din_prev <= din;
      rise     <= din & ~din_prev;
      fall     <= ~din & din_prev;
    end
  end

  assign din = sync_q[SYNC_STAGES-1];

  always_comb begin
    chan_state = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      chan_state[2*i +: 2] = state_q[i];
    end
  end

endmodule
